// File: rtl/ccc_apb_reconfig.sv
// APB initiator that issues one CCC register access per host command, then waits
// for BUSY to clear and (with CCC_APB_LOCK_WAIT_EN) for a stable PLL LOCK.
module ccc_apb_reconfig #(
  parameter int BUSY_TIMEOUT = 1023,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int LOCK_STABLE  = 16
) (
  input  logic       PCLK,
  input  logic       PRESET_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [5:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       resp_valid,
  output logic [7:0] resp_rdata,
  output logic       resp_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       BUSY,
  input  logic       LOCK,
  output logic       lock_lost
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, BUSY_WAIT, LOCK_WAIT, RESP} state_t;

  localparam logic [15:0] BUSY_TO = 16'(BUSY_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_inc;
  logic        err_q, err_nxt, resp_q;
  logic [7:0]  rdata_q;

  assign timer_inc  = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  assign cmd_ready  = (state == IDLE);
  assign resp_valid = resp_q;
  assign resp_err   = resp_q & err_q;
  assign resp_rdata = rdata_q;

`ifdef CCC_APB_LOCK_WAIT_EN
  localparam logic [15:0] LOCK_TO = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] LOCK_ST = 16'(LOCK_STABLE);

  logic [15:0] stable, stable_nxt;
  logic        lock_q, lock_lost_q;

  assign stable_nxt = !LOCK ? 16'd0 : (stable == 16'hFFFF) ? stable : stable + 16'd1;
  assign lock_lost  = lock_lost_q;
`else
  logic unused_lock;
  assign unused_lock = LOCK ^ (LOCK_TIMEOUT == 0) ^ (LOCK_STABLE == 0);
  assign lock_lost   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = err_q;
    case (state)
      IDLE: if (cmd_valid) begin
        state_nxt = SETUP;
        err_nxt   = 1'b0;
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: state_nxt = PWRITE ? BUSY_WAIT : RESP;
      BUSY_WAIT: begin
        // A BUSY release in the final cycle still counts as success
        if (!BUSY) begin
`ifdef CCC_APB_LOCK_WAIT_EN
          state_nxt = LOCK_WAIT;
`else
          state_nxt = RESP;
`endif
        end else if (timer_inc >= BUSY_TO) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
`ifdef CCC_APB_LOCK_WAIT_EN
      LOCK_WAIT: begin
        if (stable_nxt >= LOCK_ST) begin
          state_nxt = RESP;
        end else if (timer_inc >= LOCK_TO) begin
          state_nxt = RESP;
          err_nxt   = 1'b1;
        end
      end
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // APB strobes are registered from the next state so they never glitch
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state   <= IDLE;
      timer   <= 16'd0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 8'd0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= 6'd0;
      PWDATA  <= 8'd0;
    end else begin
      state   <= state_nxt;
      err_q   <= err_nxt;
      resp_q  <= (state_nxt == RESP);
      PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      PENABLE <= (state_nxt == ACCESS);
      if (state == IDLE && cmd_valid) begin
        PWRITE <= cmd_write;
        PADDR  <= cmd_addr;
        PWDATA <= cmd_wdata;
      end
      if (state == ACCESS) rdata_q <= PWRITE ? 8'd0 : PRDATA;
      timer <= ((state_nxt == state) && (state == BUSY_WAIT || state == LOCK_WAIT)) ? timer_inc : 16'd0;
    end
  end

`ifdef CCC_APB_LOCK_WAIT_EN
  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      stable      <= 16'd0;
      lock_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      stable      <= (state == LOCK_WAIT && state_nxt == LOCK_WAIT) ? stable_nxt : 16'd0;
      lock_q      <= LOCK;
      lock_lost_q <= lock_q & ~LOCK & (state == IDLE);
    end
  end
`endif

endmodule

// File: tb/tb_ccc_apb_reconfig.sv
// Bench for ccc_apb_reconfig: table of single commands plus hand sequences for
// BUSY timeout, LOCK stability/timeout, lock_lost and mid-transfer reset.
module tb_ccc_apb_reconfig;

  localparam int BUSY_TO = 1023;
  localparam int LOCK_TO = 300;
  localparam int LOCK_ST = 16;
  localparam int LIMIT   = 5000;
`ifdef CCC_APB_LOCK_WAIT_EN
  localparam int LW       = LOCK_ST;
  localparam bit HAS_LOCK = 1'b1;
`else
  localparam int LW       = 0;
  localparam bit HAS_LOCK = 1'b0;
`endif

  logic       PCLK, PRESET_N;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       resp_valid, resp_err;
  logic [7:0] resp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [5:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       BUSY, LOCK, lock_lost;

  ccc_apb_reconfig #(.BUSY_TIMEOUT(BUSY_TO), .LOCK_TIMEOUT(LOCK_TO), .LOCK_STABLE(LOCK_ST)) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .BUSY(BUSY), .LOCK(LOCK), .lock_lost(lock_lost)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] prdata;
    int         busy;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  exp_t sb[$];
  bit   lock_pat[$];
  int   checks, errors, cyc, busy_left, ll_cnt, resp_seen;
  bit   busy_stuck, lock_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One negedge step: drive BUSY/LOCK for the coming cycle and score any response.
  task automatic tick();
    exp_t e;
    @(negedge PCLK);
    cyc++;
    if (busy_left > 0) begin BUSY = 1'b1; busy_left--; end
    else BUSY = busy_stuck;
    if (lock_pat.size() > 0) LOCK = lock_pat.pop_front();
    else LOCK = lock_idle;
    if (lock_lost === 1'b1) ll_cnt++;
    if (resp_valid === 1'b1) begin
      resp_seen++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", resp_err, e.err);
        chk("resp_latency", cyc - e.acc, e.lat);
      end
    end
  endtask

  // lock_mode: 0 = idle level, 1 = 10 high / 1 low / 16 high, 2 = held low
  task automatic do_cmd(input logic wr, input logic [5:0] addr, input logic [7:0] wdata,
                        input logic [7:0] prdata, input int busy, input int lock_mode,
                        input logic [7:0] exp_rdata, input logic exp_err, input int exp_lat);
    exp_t e;
    tick();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; PRDATA = prdata;
    for (int n = 0; n < 100 && cmd_ready !== 1'b1; n++) tick();
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=%b expected 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    e.rdata = exp_rdata; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
    sb.push_back(e);
    busy_left = busy;
    if (lock_mode != 0) repeat (3) lock_pat.push_back(1'b0);
    if (lock_mode == 1) begin
      repeat (10) lock_pat.push_back(1'b1);
      lock_pat.push_back(1'b0);
      repeat (16) lock_pat.push_back(1'b1);
    end else if (lock_mode == 2) begin
      repeat (LOCK_TO + 2) lock_pat.push_back(1'b0);
    end
    tick();
    cmd_valid = 1'b0;
    chk("setup_psel", PSEL, 1); chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, addr); chk("setup_pwrite", PWRITE, wr); chk("setup_pwdata", PWDATA, wdata);
    tick();
    chk("access_psel", PSEL, 1); chk("access_penable", PENABLE, 1);
    chk("access_paddr", PADDR, addr); chk("access_pwrite", PWRITE, wr); chk("access_pwdata", PWDATA, wdata);
    tick();
    chk("post_psel", PSEL, 0); chk("post_penable", PENABLE, 0);
    for (int n = 0; n < LIMIT && sb.size() > 0; n++) tick();
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_valid expected one within %0d cycles", LIMIT);
      sb.delete();
    end
  endtask

  vec_t vecs[8];
  int   ll0, rs0;

  initial begin
    checks = 0; errors = 0; cyc = 0; busy_left = 0; ll_cnt = 0; resp_seen = 0;
    busy_stuck = 1'b0; lock_idle = 1'b1;
    PRESET_N = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    PRDATA = '0; BUSY = 1'b0; LOCK = 1'b1;

    //               wr    addr   wdata  prdata busy  rdata  latency
    vecs[0] = '{1'b0, 6'h05, 8'h00, 8'hA7, 0,  8'hA7, 3};
    vecs[1] = '{1'b1, 6'h12, 8'h3C, 8'hEE, 10, 8'h00, 12 + LW};
    vecs[2] = '{1'b1, 6'h3F, 8'hFF, 8'hEE, 0,  8'h00, 4 + LW};
    vecs[3] = '{1'b0, 6'h00, 8'h00, 8'h00, 0,  8'h00, 3};
    vecs[4] = '{1'b0, 6'h2A, 8'h99, 8'h5A, 0,  8'h5A, 3};
    vecs[5] = '{1'b1, 6'h01, 8'h00, 8'h11, 2,  8'h00, 4 + LW};
    vecs[6] = '{1'b1, 6'h20, 8'h81, 8'h22, 3,  8'h00, 5 + LW};
    vecs[7] = '{1'b0, 6'h3F, 8'h00, 8'hFF, 0,  8'hFF, 3};

    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 1); chk("rst_psel", PSEL, 0); chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0); chk("rst_paddr", PADDR, 0); chk("rst_pwdata", PWDATA, 0);
    chk("rst_resp_valid", resp_valid, 0); chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_rdata", resp_rdata, 0); chk("rst_lock_lost", lock_lost, 0);
    PRESET_N = 1'b1;
    repeat (2) tick();

    foreach (vecs[i])
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].prdata, vecs[i].busy, 0,
             vecs[i].exp_rdata, 1'b0, vecs[i].exp_lat);

    // BUSY stuck high: error after the full timeout, then a normal read
    busy_stuck = 1'b1;
    do_cmd(1'b1, 6'h10, 8'h55, 8'h00, 0, 0, 8'h00, 1'b1, 3 + BUSY_TO);
    busy_stuck = 1'b0;
    do_cmd(1'b0, 6'h07, 8'h00, 8'h42, 0, 0, 8'h42, 1'b0, 3);

    // LOCK falling in IDLE: one pulse when the lock wait is built, none otherwise
    repeat (3) tick();
    ll0 = ll_cnt;
    lock_idle = 1'b0;
    repeat (4) tick();
    chk("lock_lost_idle_pulses", ll_cnt - ll0, HAS_LOCK ? 1 : 0);
    lock_idle = 1'b1;
    repeat (3) tick();

`ifdef CCC_APB_LOCK_WAIT_EN
    ll0 = ll_cnt;
    do_cmd(1'b1, 6'h15, 8'hA5, 8'h00, 0, 1, 8'h00, 1'b0, 4 + 27);
    chk("lock_lost_in_lock_wait", ll_cnt - ll0, 0);
    do_cmd(1'b1, 6'h16, 8'h5A, 8'h00, 0, 2, 8'h00, 1'b1, 4 + LOCK_TO);
    repeat (3) tick();
`endif

    // Reset during ACCESS: strobes drop at once, no response, then a clean read
    rs0 = resp_seen;
    tick();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'h05; PRDATA = 8'h11;
    chk("rst_seq_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rst_seq_access_penable", PENABLE, 1);
    #1 PRESET_N = 1'b0;
    #1;
    chk("rst_seq_psel", PSEL, 0); chk("rst_seq_penable", PENABLE, 0);
    chk("rst_seq_cmd_ready", cmd_ready, 1); chk("rst_seq_paddr", PADDR, 0);
    repeat (2) tick();
    PRESET_N = 1'b1;
    repeat (6) tick();
    chk("rst_seq_no_resp", resp_seen - rs0, 0);
    do_cmd(1'b0, 6'h05, 8'h00, 8'hA7, 0, 0, 8'hA7, 1'b0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccc_apb_reconfig.md
CCC_APB_RECONFIG -- requirements
Module: ccc_apb_reconfig

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: PCLK (rising edge) and PRESET_N.
REQ-002 Parameter BUSY_TIMEOUT, default 1023: maximum cycles to wait for the CCC BUSY signal to clear.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum cycles to wait for a stable LOCK.
REQ-004 Parameter LOCK_STABLE, default 16: consecutive LOCK-high cycles that count as locked.
REQ-005 The ports SHALL be as follows:
- PCLK  in  1  APB/system clock.
- PRESET_N  in  1  async active-low reset.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  block idle and accepting.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  6  CCC register address.
- cmd_wdata  in  8  write data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  8  captured read data; 0 for writes.
- resp_err  out  1  timeout flag, valid with resp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB initiator controls to the CCC.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  CCC read data.
- BUSY  in  1  CCC reconfiguration busy.
- LOCK  in  1  CCC PLL lock.
- lock_lost  out  1  one-cycle pulse on a LOCK 1->0 edge while idle.

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, ACCESS, BUSY_WAIT, LOCK_WAIT and RESP.
REQ-007 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a cycle where cmd_valid and cmd_ready are both 1.
REQ-008 On accept, the block SHALL register cmd_write, cmd_addr and cmd_wdata and move to SETUP.
- SETUP: PSEL=1, PENABLE=0.
- PADDR, PWRITE and PWDATA hold the registered values through SETUP and ACCESS.
REQ-009 ACCESS SHALL last exactly one cycle with PSEL=1 and PENABLE=1, because the CCC port has no PREADY.
- Reads: PRDATA is captured at the end of ACCESS.
- PSEL and PENABLE return to 0 on the next cycle.
REQ-010 After a read, ACCESS SHALL go to RESP; after a write, it SHALL go to BUSY_WAIT.
REQ-011 BUSY_WAIT:
- Timer starts at 0 on entry.
- BUSY==0 sampled -> LOCK_WAIT (or RESP without the macro).
- Timer reaching BUSY_TIMEOUT with BUSY still 1 -> RESP with resp_err=1.
REQ-012 LOCK_WAIT:
- The stable counter increments while LOCK=1 and clears to 0 whenever LOCK=0.
- Counter reaching LOCK_STABLE -> RESP with resp_err=0.
- Timer reaching LOCK_TIMEOUT first -> RESP with resp_err=1.
- If both conditions occur in the same cycle, success wins.
REQ-013 RESP SHALL last one cycle with resp_valid=1 and then return to IDLE.
- Minimum latency from accept to resp_valid: read = 3 cycles; write with BUSY already 0 and without the macro = 4 cycles.
REQ-014 Counters SHALL be 16 bits and saturate; they never wrap.
REQ-015 cmd_valid while not in IDLE SHALL be ignored; the host holds it until cmd_ready is 1.
REQ-016 lock_lost SHALL be generated from a one-cycle registered copy of LOCK and SHALL be suppressed outside IDLE.
REQ-017 APB outputs SHALL change only on PCLK edges and SHALL never glitch between SETUP and ACCESS.

Reset
REQ-018 While PRESET_N=0, including in the middle of a transfer:
- FSM = IDLE and all counters = 0.
- PSEL, PENABLE, PWRITE, resp_valid, resp_err and lock_lost = 0.
- PADDR, PWDATA and resp_rdata = 0.
- cmd_ready = 1.
REQ-019 Reset assertion SHALL be asynchronous; deassertion SHALL take effect on the next PCLK rising edge, and no partial response is ever issued.

Configuration
REQ-020 Macro CCC_APB_LOCK_WAIT_EN SHALL control the LOCK_WAIT state:
- Defined: LOCK_WAIT, its counters and lock_lost are built in.
- Undefined: BUSY_WAIT goes directly to RESP; lock_lost is tied to 0 and LOCK is unused.

Verification
REQ-021 Read: cmd addr=0x05 with PRDATA=0xA7 -> one SETUP cycle then one ACCESS cycle; resp_valid 3 cycles after accept, resp_rdata=0xA7, resp_err=0.
REQ-022 Write with BUSY held high for 10 cycles, addr=0x12, data=0x3C:
- PWRITE=1, PADDR=0x12, PWDATA=0x3C during SETUP and ACCESS.
- resp_valid after BUSY falls, resp_err=0.
REQ-023 Write with BUSY stuck at 1 -> resp_err=1 after BUSY_TIMEOUT=1023 cycles in BUSY_WAIT; the next command is accepted.
REQ-024 CCC_APB_LOCK_WAIT_EN defined, LOCK toggling: 10 cycles high, 1 low, then 16 high -> success only after the 16 consecutive high cycles; LOCK held low -> resp_err=1 at LOCK_TIMEOUT.
REQ-025 PRESET_N pulsed low during ACCESS -> PSEL and PENABLE drop to 0 immediately, no resp_valid, cmd_ready=1; a subsequent read completes normally.
REQ-026 In IDLE, LOCK 1->0 -> lock_lost high for exactly one cycle; the same edge during LOCK_WAIT -> no pulse.
